// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between icache and dcache: dcache priority with starvation guard.
// Optional completion counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              merr,
    output logic [31:0]       icount,
    output logic [31:0]       dcount
);

    typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_e;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       i_done, d_done;
    logic       ipri;

    assign iload = ramload;
    assign dload = ramload;
    assign ipri  = iREN && (starve_cnt_q == STARVE_LIM);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        merr     = 1'b0;
        i_done   = 1'b0;
        d_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ipri)              state_d = ISERV;
                else if (dREN || dWEN) state_d = DSERV;
                else if (iREN)         state_d = ISERV;
            end
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dREN && !dWEN) begin
                    state_d = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = dREN && !dWEN;
                    if (ramstate == RAM_ACCESS) begin
                        dwait   = 1'b0;
                        d_done  = 1'b1;
                        state_d = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        merr    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ISERV: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ramstate == RAM_ACCESS) begin
                        iwait   = 1'b0;
                        i_done  = 1'b1;
                        state_d = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        merr    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts dcache wins while the icache keeps waiting; any icache gap restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (i_done || !iREN)
            starve_cnt_d = '0;
        else if (d_done && starve_cnt_q < STARVE_LIM)
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] icount_q, icount_d, dcount_q, dcount_d;

    always_comb begin
        icount_d = icount_q;
        dcount_d = dcount_q;
        if (i_done && icount_q != 32'hFFFF_FFFF) icount_d = icount_q + 32'd1;
        if (d_done && dcount_q != 32'hFFFF_FFFF) dcount_d = dcount_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount_q <= '0;
            dcount_q <= '0;
        end else begin
            icount_q <= icount_d;
            dcount_q <= dcount_d;
        end
    end

    assign icount = icount_q;
    assign dcount = dcount_q;
`else
    assign icount = '0;
    assign dcount = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, starvation/reset sequences,
// then randomized traffic against a grant-owner reference model.
module tb_mem_arbiter;

    localparam int SM = 4;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, merr;
    logic [31:0] iload, dload, ramaddr, ramstore, icount, dcount;

    int tests  = 0;
    int failed = 0;

    mem_arbiter #(.STARVE_MAX(SM), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .merr(merr),
        .icount(icount), .dcount(dcount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ir, dr, dw;
        logic [31:0] ia, da, ds, rl;
        logic [1:0]  rs;
        logic        e_iw, e_dw, e_ren, e_wen, e_merr;
        logic [31:0] e_addr, e_store;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic dr, input logic dw,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] ds, input logic [31:0] rl,
                                input logic [1:0] rs,
                                input logic e_iw, input logic e_dw, input logic e_ren,
                                input logic e_wen, input logic e_merr,
                                input logic [31:0] e_addr, input logic [31:0] e_store);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
        v.e_iw = e_iw; v.e_dw = e_dw; v.e_ren = e_ren; v.e_wen = e_wen; v.e_merr = e_merr;
        v.e_addr = e_addr; v.e_store = e_store;
        return v;
    endfunction

    task automatic drive_idle();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
    endtask

    task automatic apply_reset();
        drive_idle();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    // Runs with both caches requesting and the RAM answering ACCESS every cycle;
    // completions must follow d,d,d,d,i from a cleared starvation count.
    task automatic run_pattern(input string tag, input int cycles, input int exp_total);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            check({tag, "_exclusive"}, {31'b0, (!iwait && !dwait)}, 32'd0);
            if (!iwait || !dwait) begin
                check({tag, "_order"}, {31'b0, !iwait}, {31'b0, (seen % 5 == 4)});
                seen++;
            end
            @(posedge CLK);
            #1;
        end
        check({tag, "_total"}, seen, exp_total);
    endtask

    // Reference model: who owns the RAM port, and how long the icache has been passed over.
    int     own;  // 0 none, 1 dcache, 2 icache
    int     starve;
    longint m_icnt, m_dcnt;

    initial begin
        vec_t vecs[21];
        logic e_iw, e_dw, e_ren, e_wen, e_merr, d_done, i_done, fin;
        logic [31:0] e_addr, e_store;

        nRST = 1'b0;
        drive_idle();
        #3;
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_ramREN", ramREN, 0);
        check("rst_ramWEN", ramWEN, 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_ramstore", ramstore, 0);
        check("rst_merr", merr, 0);
        check("rst_icount", icount, 0);
        check("rst_dcount", dcount, 0);
        apply_reset();

        //                ir dr dw  iaddr      daddr      dstore  ramload       rs   iw dw ren wen merr addr       store
        vecs[0]  = mk(0, 1, 0, 32'h0,   32'h40,   32'h0, 32'h0,        2'd1, 1, 1, 0, 0, 0, 32'h0,    32'h0);
        vecs[1]  = mk(0, 1, 0, 32'h0,   32'h40,   32'h0, 32'h0,        2'd1, 1, 1, 1, 0, 0, 32'h40,   32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h0,   32'h40,   32'h0, 32'h0,        2'd1, 1, 1, 1, 0, 0, 32'h40,   32'h0);
        vecs[3]  = mk(0, 1, 0, 32'h0,   32'h40,   32'h0, 32'hDEADBEEF, 2'd2, 1, 0, 1, 0, 0, 32'h40,   32'h0);
        vecs[4]  = mk(0, 0, 0, 32'h0,   32'h0,    32'h0, 32'h0,        2'd0, 1, 1, 0, 0, 0, 32'h0,    32'h0);
        vecs[5]  = mk(0, 1, 1, 32'h0,   32'h3100, 32'h5, 32'h0,        2'd0, 1, 1, 0, 0, 0, 32'h0,    32'h0);
        vecs[6]  = mk(0, 1, 1, 32'h0,   32'h3100, 32'h5, 32'h0,        2'd0, 1, 1, 0, 1, 0, 32'h3100, 32'h5);
        vecs[7]  = mk(0, 1, 1, 32'h0,   32'h3100, 32'h5, 32'h0,        2'd2, 1, 0, 0, 1, 0, 32'h3100, 32'h5);
        vecs[8]  = mk(0, 0, 0, 32'h0,   32'h0,    32'h0, 32'h0,        2'd0, 1, 1, 0, 0, 0, 32'h0,    32'h0);
        vecs[9]  = mk(1, 0, 0, 32'h100, 32'h0,    32'h0, 32'h0,        2'd1, 1, 1, 0, 0, 0, 32'h0,    32'h0);
        vecs[10] = mk(1, 0, 0, 32'h100, 32'h0,    32'h0, 32'h0,        2'd1, 1, 1, 1, 0, 0, 32'h100,  32'h0);
        vecs[11] = mk(0, 0, 0, 32'h100, 32'h0,    32'h0, 32'h0,        2'd1, 1, 1, 0, 0, 0, 32'h100,  32'h0);
        vecs[12] = mk(0, 0, 0, 32'h0,   32'h0,    32'h0, 32'h0,        2'd0, 1, 1, 0, 0, 0, 32'h0,    32'h0);
        vecs[13] = mk(0, 1, 0, 32'h0,   32'h80,   32'h0, 32'h0,        2'd0, 1, 1, 0, 0, 0, 32'h0,    32'h0);
        vecs[14] = mk(0, 1, 0, 32'h0,   32'h80,   32'h0, 32'h0,        2'd3, 1, 1, 1, 0, 1, 32'h80,   32'h0);
        vecs[15] = mk(0, 1, 0, 32'h0,   32'h80,   32'h0, 32'h1234,     2'd2, 1, 1, 0, 0, 0, 32'h0,    32'h0);
        vecs[16] = mk(0, 1, 0, 32'h0,   32'h80,   32'h0, 32'h1234,     2'd2, 1, 0, 1, 0, 0, 32'h80,   32'h0);
        vecs[17] = mk(0, 0, 0, 32'h0,   32'h0,    32'h0, 32'h0,        2'd0, 1, 1, 0, 0, 0, 32'h0,    32'h0);
        vecs[18] = mk(1, 0, 0, 32'h200, 32'h0,    32'h0, 32'h77,       2'd2, 1, 1, 0, 0, 0, 32'h0,    32'h0);
        vecs[19] = mk(1, 0, 0, 32'h200, 32'h0,    32'h0, 32'h77,       2'd2, 0, 1, 1, 0, 0, 32'h200,  32'h0);
        vecs[20] = mk(0, 0, 0, 32'h0,   32'h0,    32'h0, 32'h0,        2'd0, 1, 1, 0, 0, 0, 32'h0,    32'h0);

        for (int i = 0; i < 21; i++) begin
            iREN = vecs[i].ir; dREN = vecs[i].dr; dWEN = vecs[i].dw;
            iaddr = vecs[i].ia; daddr = vecs[i].da; dstore = vecs[i].ds;
            ramload = vecs[i].rl; ramstate = vecs[i].rs;
            @(negedge CLK);
            check($sformatf("vec%0d_iwait", i), iwait, vecs[i].e_iw);
            check($sformatf("vec%0d_dwait", i), dwait, vecs[i].e_dw);
            check($sformatf("vec%0d_ramREN", i), ramREN, vecs[i].e_ren);
            check($sformatf("vec%0d_ramWEN", i), ramWEN, vecs[i].e_wen);
            check($sformatf("vec%0d_merr", i), merr, vecs[i].e_merr);
            check($sformatf("vec%0d_ramaddr", i), ramaddr, vecs[i].e_addr);
            check($sformatf("vec%0d_ramstore", i), ramstore, vecs[i].e_store);
            check($sformatf("vec%0d_dload", i), dload, vecs[i].rl);
            check($sformatf("vec%0d_iload", i), iload, vecs[i].rl);
            @(posedge CLK);
            #1;
        end
`ifdef MEM_ARB_STATS_EN
        check("tbl_icount", icount, 1);
        check("tbl_dcount", dcount, 3);
`else
        check("tbl_icount", icount, 0);
        check("tbl_dcount", dcount, 0);
`endif

        // Starvation guard: 4 dcache completions, then the icache, repeating.
        drive_idle();
        iREN = 1; dREN = 1; ramstate = 2'd2;
        run_pattern("starve", 30, 15);

        // Build up three dcache wins, then reset in the middle of a dcache service.
        repeat (6) begin
            @(posedge CLK);
            #1;
        end
        ramstate = 2'd1;
        @(posedge CLK);
        #1;
        check("pre_rst_ramREN", ramREN, 1);
        nRST = 1'b0;
        #1;
        check("async_rst_ramREN", ramREN, 0);
        check("async_rst_ramWEN", ramWEN, 0);
        check("async_rst_dwait", dwait, 1);
        check("async_rst_iwait", iwait, 1);
        check("async_rst_icount", icount, 0);
        check("async_rst_dcount", dcount, 0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        ramstate = 2'd2;
        run_pattern("post_rst", 10, 5);

        // Randomized traffic against the reference model.
        apply_reset();
        own = 0; starve = 0; m_icnt = 0; m_dcnt = 0;
        for (int c = 0; c < 400; c++) begin
            iREN     = ($urandom_range(0, 3) != 0);
            dREN     = $urandom_range(0, 1) == 1;
            dWEN     = $urandom_range(0, 3) == 0;
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = 2'($urandom_range(0, 3));

            e_iw = 1; e_dw = 1; e_ren = 0; e_wen = 0; e_merr = 0;
            e_addr = 0; e_store = 0; d_done = 0; i_done = 0; fin = 0;
            if (own == 1) begin
                e_addr = daddr; e_store = dstore;
                if (!dREN && !dWEN) fin = 1;
                else begin
                    if (dWEN) e_wen = 1; else e_ren = 1;
                    if (ramstate == 2'd2) begin e_dw = 0; d_done = 1; fin = 1; end
                    else if (ramstate == 2'd3) begin e_merr = 1; fin = 1; end
                end
            end else if (own == 2) begin
                e_addr = iaddr;
                if (!iREN) fin = 1;
                else begin
                    e_ren = 1;
                    if (ramstate == 2'd2) begin e_iw = 0; i_done = 1; fin = 1; end
                    else if (ramstate == 2'd3) begin e_merr = 1; fin = 1; end
                end
            end

            @(negedge CLK);
            check("rnd_iwait", iwait, e_iw);
            check("rnd_dwait", dwait, e_dw);
            check("rnd_ramREN", ramREN, e_ren);
            check("rnd_ramWEN", ramWEN, e_wen);
            check("rnd_merr", merr, e_merr);
            check("rnd_ramaddr", ramaddr, e_addr);
            check("rnd_ramstore", ramstore, e_store);
            check("rnd_dload", dload, ramload);
`ifdef MEM_ARB_STATS_EN
            check("rnd_icount", icount, 32'(m_icnt));
            check("rnd_dcount", dcount, 32'(m_dcnt));
`else
            check("rnd_icount", icount, 0);
            check("rnd_dcount", dcount, 0);
`endif
            @(posedge CLK);
            if (own == 0) begin
                if (iREN && starve == SM) own = 2;
                else if (dREN || dWEN)    own = 1;
                else if (iREN)            own = 2;
            end else if (fin) begin
                own = 0;
            end
            if (i_done || !iREN)              starve = 0;
            else if (d_done && starve < SM)   starve = starve + 1;
            if (i_done) m_icnt++;
            if (d_done) m_dcnt++;
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the icache and the dcache. Each cache sees its own request/wait handshake.
- A registered FSM grants one requester at a time and holds the grant until the RAM reports ACCESS, ERROR, or the requester drops its request.
- dcache has priority. A starvation counter forces an icache grant after STARVE_MAX consecutive dcache services while the icache is waiting.

Parameters:
- STARVE_MAX, 4: max consecutive dcache completions while iREN is pending before the icache is forced in; legal range 1..15.
- ADDR_W, 32: width of the address and data words.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache address
- iwait  out  1  low for exactly the cycle an icache read completes
- iload  out  ADDR_W  icache read data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache address
- dstore  in  ADDR_W  dcache write data
- dwait  out  1  low for exactly the cycle a dcache access completes
- dload  out  ADDR_W  dcache read data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  ADDR_W  RAM write data
- ramload  in  ADDR_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- merr  out  1  one-cycle pulse on a RAM ERROR
- icount  out  32  icache completion count (stats feature)
- dcount  out  32  dcache completion count (stats feature)

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values:
  - state=IDLE, starve_cnt=0, icount=dcount=0.
  - Combinational outputs with no grant: iwait=1, dwait=1, ramREN=ramWEN=0, ramaddr=0, ramstore=0, merr=0.
- States: IDLE, DSERV, ISERV. Transitions are registered, so arbitration latency is 1 cycle from request to RAM strobe.
- IDLE:
  - ipri = iREN & (starve_cnt==STARVE_MAX).
  - If ipri: go to ISERV.
  - Else if dREN|dWEN: go to DSERV.
  - Else if iREN: go to ISERV.
  - Otherwise stay in IDLE. No RAM strobes are driven in IDLE.
- DSERV:
  - Drive ramaddr=daddr and ramstore=dstore.
  - If dWEN: ramWEN=1 (write wins when both are set). Otherwise ramREN=dREN.
  - ramstate==ACCESS: dwait=0 this cycle, dload=ramload, go to IDLE.
  - ramstate==ERROR: dwait stays 1, merr=1, go to IDLE. The requester retries.
  - dREN=dWEN=0 (request dropped): deassert strobes this cycle, go to IDLE. No completion, no count.
  - FREE or BUSY: hold.
- ISERV: same as DSERV with ramaddr=iaddr, ramREN=1, iwait/iload in place of dwait/dload, and abort on iREN=0.
- Waits: the non-granted requester's wait is always 1. iload=dload=ramload at all times; data is valid only in the completion cycle.
- starve_cnt (4 bits):
  - Cleared on icache completion, or in any cycle with iREN=0.
  - Otherwise +1 on a dcache completion while iREN=1, saturating at STARVE_MAX.
- Simultaneous events: in IDLE with both caches requesting and starve_cnt<STARVE_MAX, the dcache wins.
- Reset mid-service: immediate return to IDLE, strobes drop asynchronously, and the transaction is lost.
- Back-to-back: every completion passes through IDLE, so each access costs at least 2 cycles (grant + RAM latency).

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - icount/dcount increment on each icache/dcache completion (ACCESS cycle), saturating at 32'hFFFFFFFF.
  - Aborts and errors are not counted.
- Undefined: counters are not built; icount and dcount are tied to 0.
- Arbitration is identical either way.

Test Plan:
- dcache only, dREN=1, daddr=32'h40, RAM answers ACCESS after 2 BUSY cycles with ramload=32'hDEADBEEF: ramREN asserted from cycle 1, dwait=0 and dload=32'hDEADBEEF in cycle 3, then IDLE; with MEM_ARB_STATS_EN, dcount=1.
- dWEN=1 and dREN=1 together, daddr=32'h3100, dstore=32'h5: ramWEN=1, ramREN=0, ramstore=32'h5, ramaddr=32'h3100.
- iREN and dREN both held high, STARVE_MAX=4, RAM ACCESS every cycle: 4 dcache completions, then 1 icache completion, then repeat; iwait is never low while the dcache is granted.
- ISERV with iREN dropped before ACCESS: ramREN falls the same cycle, FSM returns to IDLE, icount unchanged, iwait stays 1.
- ramstate=ERROR during DSERV: merr pulses 1 cycle, dwait stays 1, next-cycle re-grant to the dcache if still requesting.
- nRST asserted mid-DSERV: ramREN/ramWEN go to 0 without a clock edge, starve_cnt=0, state=IDLE, counters=0.
